// File: rtl/logic_arb_pkg.sv
// Shared encodings for the logic-unit arbiter: operation codes and FSM states.
package logic_arb_pkg;

  localparam logic [1:0] LOP_AND = 2'b00;
  localparam logic [1:0] LOP_OR  = 2'b01;
  localparam logic [1:0] LOP_XOR = 2'b10;
  localparam logic [1:0] LOP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] idx_o
);

  logic            found;
  logic [IDXW-1:0] cand;

  // First requester at or after last+1 (mod NREQ) wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = IDXW'((int'(last_i) + i) % int'(NREQ));
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one registered bitwise logic unit among NREQ requesters using round-robin
// arbitration and an IDLE -> EXEC -> RESP sequence per operation.
// Optional feature: define LOGIC_ARB_ZERO_FLAG_EN to add the rsp_zero output.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  ,
  output logic                  rsp_zero
`endif
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q;
  logic [IDXW-1:0] grant_q;
  logic [IDXW-1:0] last_q;
  logic [1:0]      op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [NREQ-1:0] rsp_valid_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  logic            zero_q;
`endif

  logic [NREQ-1:0]  win_gnt;
  logic [IDXW-1:0]  win_idx;
  logic [WIDTH-1:0] op_result;

  logic [1:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign op_arr[g] = req_op[2*g +: 2];
    assign a_arr[g]  = req_a[WIDTH*g +: WIDTH];
    assign b_arr[g]  = req_b[WIDTH*g +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx)
  );

  // Logic unit operating on the latched operands
  always_comb begin
    op_result = '0;
    unique case (op_q)
      LOP_AND: op_result = a_q & b_q;
      LOP_OR:  op_result = a_q | b_q;
      LOP_XOR: op_result = a_q ^ b_q;
      LOP_NOR: op_result = ~(a_q | b_q);
      default: op_result = '0;
    endcase
  end

  // Arbitration FSM with operand, result and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= IDXW'(NREQ - 1);
      op_q        <= LOP_AND;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      rsp_valid_q <= '0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q <= win_idx;
            op_q    <= op_arr[win_idx];
            a_q     <= a_arr[win_idx];
            b_q     <= b_arr[win_idx];
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q             <= op_result;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
          zero_q               <= (op_result == '0);
`endif
          rsp_valid_q          <= '0;
          rsp_valid_q[grant_q] <= 1'b1;
          state_q              <= S_RESP;
        end
        S_RESP: begin
          // Only the granted requester's rsp_ready can retire the response
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            last_q      <= grant_q;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE) ? win_gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = result_q;
  assign busy      = (state_q != S_IDLE);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  assign rsp_zero  = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the arbiter.
module tb_logic_unit_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  logic                  rsp_zero;
`endif

  logic [1:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  int n_vec = 0;
  int n_err = 0;

  // Model state: one transaction in flight, its age in cycles, and the last retired grant
  bit               m_fly;
  int               m_age;
  int               m_grant;
  int               m_last;
  logic [WIDTH-1:0] m_res;

  always #5 clk = ~clk;

  always_comb begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]     = op_arr[i];
      req_a[WIDTH*i +: WIDTH] = a_arr[i];
      req_b[WIDTH*i +: WIDTH] = b_arr[i];
    end
  end

  logic_unit_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  function automatic logic [NREQ-1:0] onehot(int i);
    logic [NREQ-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic logic [WIDTH-1:0] calc(logic [1:0] op, logic [WIDTH-1:0] a,
                                            logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int winner(logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_last + k) % NREQ;
      if (|(v & onehot(c))) return c;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fly   = 1'b0;
    m_age   = 0;
    m_grant = 0;
    m_last  = NREQ - 1;
  endtask

  task automatic check_model();
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] ev;
    int w;
    w  = winner(req_valid);
    er = (!m_fly && w >= 0) ? onehot(w) : '0;
    ev = (m_fly && m_age >= 1) ? onehot(m_grant) : '0;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_fly);
    chk("rsp_valid", rsp_valid, ev);
    if (ev != '0) begin
      chk("rsp_data", rsp_data, m_res);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      chk("rsp_zero", rsp_zero, m_res == '0);
`endif
    end
  endtask

  // Applies the effect of the coming rising edge using the inputs now being driven
  task automatic advance_model();
    int w;
    if (rst_n) begin
      if (!m_fly) begin
        w = winner(req_valid);
        if (w >= 0) begin
          m_fly   = 1'b1;
          m_age   = 0;
          m_grant = w;
          m_res   = calc(op_arr[w], a_arr[w], b_arr[w]);
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (|(rsp_ready & onehot(m_grant))) begin
        m_fly  = 1'b0;
        m_last = m_grant;
      end
    end
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic adv();
    advance_model();
    @(negedge clk);
  endtask

  // One isolated operation with literal timing and data expectations; starts and ends idle
  task automatic do_op(int idx, logic [1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                       logic [WIDTH-1:0] exp);
    req_valid   = onehot(idx);
    rsp_ready   = '1;
    op_arr[idx] = op;
    a_arr[idx]  = a;
    b_arr[idx]  = b;
    settle();
    chk("c0_req_ready", req_ready, onehot(idx));
    chk("c0_busy", busy, 1'b0);
    adv();
    req_valid = '0;
    settle();
    chk("c1_busy", busy, 1'b1);
    chk("c1_rsp_valid", rsp_valid, '0);
    adv();
    settle();
    chk("c2_busy", busy, 1'b1);
    chk("c2_rsp_valid", rsp_valid, onehot(idx));
    chk("c2_rsp_data", rsp_data, exp);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    chk("c2_rsp_zero", rsp_zero, exp == '0);
`endif
    adv();
    settle();
    chk("c3_busy", busy, 1'b0);
    adv();
  endtask

  initial begin
    int seq [8];
    int nseq;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = '0;
      a_arr[i]  = '0;
      b_arr[i]  = '0;
    end
    model_reset();
    #1;
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_data", rsp_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single OR on requester 0
    do_op(0, 2'b01, 32'h0000_F0F0, 32'h0F0F_0000, 32'h0F0F_F0F0);

    // All four operations on requester 1
    do_op(1, 2'b00, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFF00_0000);
    do_op(1, 2'b01, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFFFF_FF00);
    do_op(1, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
    do_op(1, 2'b11, 32'hFFFF_0000, 32'hFF00_FF00, 32'h0000_00FF);

`ifdef LOGIC_ARB_ZERO_FLAG_EN
    do_op(0, 2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
    do_op(0, 2'b10, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001);
    do_op(1, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
`endif

    // Both requesters held valid: strict rotation
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = 2'($urandom);
      a_arr[i]  = $urandom;
      b_arr[i]  = $urandom;
    end
    nseq = 0;
    for (int c = 0; c < 18; c++) begin
      settle();
      chk("ready_onehot0", $onehot0(req_ready), 1'b1);
      if (req_ready != '0 && nseq < 8) begin
        seq[nseq] = (req_ready == 2'b01) ? 0 : 1;
        nseq++;
      end
      adv();
    end
    req_valid = '0;
    chk("rotation_count", nseq, 6);
    for (int k = 0; k < 6; k++) chk("rotation_grant", seq[k], k % 2);

    // Back-pressure on requester 0
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    op_arr[0] = 2'b00;
    a_arr[0]  = 32'hDEAD_BEEF;
    b_arr[0]  = 32'h0FF0_0FF0;
    settle();
    chk("bp_accept", req_ready, 2'b01);
    adv();
    req_valid = 2'b11;
    settle();
    adv();
    for (int c = 0; c < 10; c++) begin
      rsp_ready = (c >= 5) ? 2'b10 : 2'b00;
      settle();
      chk("bp_rsp_valid", rsp_valid, 2'b01);
      chk("bp_rsp_data", rsp_data, 32'h0EA0_0EE0);
      chk("bp_req_ready", req_ready, 2'b00);
      adv();
    end
    rsp_ready = 2'b01;
    settle();
    chk("bp_release_valid", rsp_valid, 2'b01);
    adv();
    settle();
    chk("bp_next_grant", req_ready, 2'b10);
    adv();
    req_valid = '0;
    rsp_ready = '1;
    for (int c = 0; c < 4; c++) begin
      settle();
      adv();
    end

    // Reset during EXEC of a requester 1 operation
    req_valid = 2'b10;
    op_arr[1] = 2'b10;
    a_arr[1]  = 32'hA5A5_0000;
    b_arr[1]  = 32'h0000_5A5A;
    settle();
    chk("rstx_accept", req_ready, 2'b10);
    adv();
    req_valid = 2'b11;
    rst_n     = 1'b0;
    model_reset();
    settle();
    chk("rstx_busy", busy, 1'b0);
    chk("rstx_rsp_valid", rsp_valid, '0);
    adv();
    rst_n = 1'b1;
    settle();
    chk("rstx_first_grant", req_ready, 2'b01);
    adv();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      settle();
      adv();
    end

    // Reset while a response is pending drops rsp_valid at once
    req_valid = 2'b10;
    rsp_ready = '0;
    settle();
    adv();
    req_valid = '0;
    settle();
    adv();
    settle();
    chk("rstr_resp_before", rsp_valid, 2'b10);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstr_rsp_valid", rsp_valid, '0);
    chk("rstr_busy", busy, 1'b0);
    adv();
    rst_n = 1'b1;

    // Randomized traffic with withdrawals, back-pressure and occasional resets
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        op_arr[i] = 2'($urandom);
        a_arr[i]  = $urandom;
        b_arr[i]  = ($urandom_range(0, 7) == 0) ? a_arr[i] : $urandom;
      end
      settle();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
